serial_receiver: RTL

SERIAL_RECEIVER -- requirements
Module: serial_receiver

---
 rtl/serial_receiver.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/serial_receiver.sv
// serial_receiver: 10-bit frame receiver (start=1, 8 data bits MSB first, stop=0).
// Optional 2-flop rxd synchronizer is enabled by defining SERIAL_RECEIVER_SYNC_EN.
module serial_receiver #(
    parameter int BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int              CW        = $clog2(BIT_CYCLES) + 1;
    localparam logic [CW-1:0]   BIT_LEN   = CW'(BIT_CYCLES);
    localparam logic [CW-1:0]   HALF_WAIT = CW'((BIT_CYCLES - 1) / 2);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO  = '0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rxd_s;
    logic          sample;

`ifdef SERIAL_RECEIVER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxd_s = sync_q[1];
`else
    assign rxd_s = rxd;
`endif

    // A sample point is the edge on which the counter holds 1; it is then reloaded.
    assign sample = (cnt_q == CNT_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rxd_s) begin
                    bit_cnt_d = 3'd0;
                    // With no mid-bit wait the detection edge is itself the start sample.
                    if (HALF_WAIT == CNT_ZERO) begin
                        state_d = DATA;
                        cnt_d   = BIT_LEN;
                    end else begin
                        state_d = START;
                        cnt_d   = HALF_WAIT;
                    end
                end
            end
            START: begin
                if (sample) begin
                    if (rxd_s) begin
                        state_d = DATA;
                        cnt_d   = BIT_LEN;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {shift_q[6:0], rxd_s};
                    cnt_d   = BIT_LEN;
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = STOP;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            STOP: begin
                if (sample) begin
                    cnt_d = CNT_ZERO;
                    if (!rxd_s) begin
                        state_d = IDLE;
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        state_d = WAIT_IDLE;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WAIT_IDLE: begin
                // A broken stop bit leaves the line high; wait for it to drop before hunting.
                if (!rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule
